// File: rtl/data_mem_ctrl.sv
// Data-memory access controller: an in-house MMIO window plus an external RAM reached through an
// en/ready handshake with a timeout. The core is stalled until each access completes.
module data_mem_ctrl #(
    parameter int unsigned MEM_AW  = 10,
    parameter logic [31:0] IO_BASE = 32'h0000_FF00,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata,
    input  logic [31:0]       io_in,
    output logic [31:0]       io_out,
    output logic              err
);

    localparam int unsigned     CW   = $clog2(TIMEOUT);
    localparam logic [CW-1:0]   LAST = CW'(TIMEOUT - 1);
    localparam logic [31:0]     ABORT_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MEM,
        S_RESP
    } state_t;

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic [31:0]       sync1_q;
    logic [31:0]       sync2_q;
    logic              rsp_valid_q;
    logic [31:0]       rsp_rdata_q;
    logic              err_q;
    logic              mem_en_q;
    logic              mem_we_q;
    logic [MEM_AW-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic [31:0]       io_out_q;

    logic        misaligned;
    logic        io_hit;
    logic [1:0]  io_sel;
    logic [31:0] io_rdata_d;

    // Window decode is done on the full 32-bit address; the 33-bit compare avoids wrap at the top.
    always_comb begin
        misaligned = (req_addr[1:0] != 2'b00);
        io_hit     = ({1'b0, req_addr} >= {1'b0, IO_BASE}) &&
                     ({1'b0, req_addr} <  ({1'b0, IO_BASE} + 33'd16));
        io_sel     = req_addr[3:2] - IO_BASE[3:2];
        io_rdata_d = '0;
        case (io_sel)
            2'd0:    io_rdata_d = io_out_q;
            2'd1:    io_rdata_d = sync2_q;
            default: io_rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            sync1_q     <= '0;
            sync2_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            err_q       <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            io_out_q    <= '0;
        end else begin
            sync1_q     <= io_in;
            sync2_q     <= sync1_q;
            rsp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        if (misaligned) begin
                            state_q     <= S_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= '0;
                            err_q       <= 1'b1;
                        end else if (io_hit) begin
                            state_q     <= S_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= req_we ? '0 : io_rdata_d;
                            if (req_we && (io_sel == 2'd0)) begin
                                io_out_q <= req_wdata;
                            end
                        end else begin
                            state_q     <= S_MEM;
                            cnt_q       <= '0;
                            mem_en_q    <= 1'b1;
                            mem_we_q    <= req_we;
                            mem_addr_q  <= req_addr[MEM_AW+1:2];
                            mem_wdata_q <= req_wdata;
                        end
                    end
                end
                S_MEM: begin
                    // A ready on the final allowed cycle takes priority over the abort.
                    if (mem_ready) begin
                        state_q     <= S_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= mem_we_q ? '0 : mem_rdata;
                        mem_en_q    <= 1'b0;
                        mem_we_q    <= 1'b0;
                    end else if (cnt_q == LAST) begin
                        state_q     <= S_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= ABORT_DATA;
                        err_q       <= 1'b1;
                        mem_en_q    <= 1'b0;
                        mem_we_q    <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign stall     = req_valid & ~rsp_valid_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign io_out    = io_out_q;
    assign err       = err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboarded bench for data_mem_ctrl: stimulus pushes expected responses, a negedge monitor
// pops and compares them whenever rsp_valid is seen.
module tb_data_mem_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        stall;
    logic        mem_en;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [31:0] io_in;
    logic [31:0] io_out;
    logic        err;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks;
    int   failures;
    bit   prev_resp;

    data_mem_ctrl #(
        .MEM_AW (10),
        .IO_BASE(32'h0000_FF00),
        .TIMEOUT(16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_we   (req_we),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .stall    (stall),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata),
        .io_in    (io_in),
        .io_out   (io_out),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst && rsp_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp actual=0x%08h expected=none", rsp_rdata);
            end else begin
                e = sb.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_err", 32'(err), 32'(e.err));
            end
        end
    end

    // ready_after: number of MEM wait cycles before mem_ready (-1 = never)
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input int ready_after, input logic [31:0] rd,
                          input logic [31:0] exp_rdata, input logic exp_err,
                          input int exp_lat, input int exp_mcyc, input logic [9:0] exp_maddr);
        exp_t e;
        int   mcyc;
        bit   done;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        sb.push_back(e);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        if (prev_resp) begin
            @(negedge clk);
            chk("gap_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("gap_mem_en", 32'(mem_en), 32'd0);
        end
        mcyc = 0;
        done = 1'b0;
        for (int c = 1; c <= 40 && !done; c++) begin
            @(negedge clk);
            chk("stall", 32'(stall), 32'(c != exp_lat));
            if (rsp_valid) begin
                done      = 1'b1;
                mem_ready = 1'b0;
                chk("latency", 32'(c), 32'(exp_lat));
            end else if (mem_en) begin
                mcyc++;
                chk("mem_we", 32'(mem_we), 32'(we));
                chk("mem_addr", 32'(mem_addr), 32'(exp_maddr));
                if (we) chk("mem_wdata", mem_wdata, wdata);
                mem_ready = (mcyc - 1 == ready_after);
                mem_rdata = rd;
            end else begin
                mem_ready = 1'b0;
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL no_response actual=none expected=rsp_valid addr=0x%08h", addr);
        end
        chk("mem_cycles", 32'(mcyc), 32'(exp_mcyc));
        prev_resp = done;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        prev_resp = 1'b0;
        repeat (n) begin
            @(negedge clk);
            chk("idle_stall", 32'(stall), 32'd0);
            chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        prev_resp = 1'b0;
        rst       = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        io_in     = 32'h5A5A_1234;

        repeat (3) @(negedge clk);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_io_out", io_out, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_stall", 32'(stall), 32'd1);
        req_valid = 1'b0;
        rst       = 1'b1;
        idle(2);

        // RAM load, ready in first MEM cycle
        access(1'b0, 32'h0000_0010, 32'h0, 0, 32'h1234_5678, 32'h1234_5678, 1'b0, 2, 1, 10'd4);
        idle(1);
        // RAM store, three wait cycles
        access(1'b1, 32'h0000_0020, 32'hCAFE_0001, 3, 32'hFFFF_FFFF, 32'h0, 1'b0, 5, 4, 10'd8);
        idle(1);

        // MMIO
        access(1'b1, 32'h0000_FF00, 32'h0000_00A5, -1, 32'h0, 32'h0, 1'b0, 1, 0, 10'd0);
        idle(1);
        chk("io_out_after_store", io_out, 32'h0000_00A5);
        access(1'b0, 32'h0000_FF00, 32'h0, -1, 32'h0, 32'h0000_00A5, 1'b0, 1, 0, 10'd0);
        access(1'b0, 32'h0000_FF04, 32'h0, -1, 32'h0, 32'h5A5A_1234, 1'b0, 1, 0, 10'd0);
        access(1'b1, 32'h0000_FF04, 32'h0000_0777, -1, 32'h0, 32'h0, 1'b0, 1, 0, 10'd0);
        access(1'b0, 32'h0000_FF08, 32'h0, -1, 32'h0, 32'h0, 1'b0, 1, 0, 10'd0);
        access(1'b0, 32'h0000_FF0C, 32'h0, -1, 32'h0, 32'h0, 1'b0, 1, 0, 10'd0);
        access(1'b0, 32'h0000_FF00, 32'h0, -1, 32'h0, 32'h0000_00A5, 1'b0, 1, 0, 10'd0);
        idle(1);
        chk("io_out_kept", io_out, 32'h0000_00A5);

        // Just past the window goes to RAM; high address bits alias
        access(1'b0, 32'h0000_FF10, 32'h0, 0, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0, 2, 1, 10'h3C4);
        access(1'b0, 32'h0001_0010, 32'h0, 1, 32'h1111_2222, 32'h1111_2222, 1'b0, 3, 2, 10'd4);
        idle(1);

        // Stray mem_ready while idle has no effect
        mem_ready = 1'b1;
        idle(3);
        mem_ready = 1'b0;
        chk("stray_ready_err", 32'(err), 32'd0);

        // Timeout, then ready on the final allowed cycle
        access(1'b0, 32'h0000_0030, 32'h0, -1, 32'h0, 32'hDEAD_BEEF, 1'b1, 17, 16, 10'd12);
        idle(1);
        chk("err_after_timeout", 32'(err), 32'd1);
        access(1'b0, 32'h0000_0034, 32'h0, 15, 32'h600D_600D, 32'h600D_600D, 1'b1, 17, 16, 10'd13);
        idle(1);
        chk("err_sticky", 32'(err), 32'd1);

        // Reset in the middle of a RAM access
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h0000_0040;
        req_wdata = 32'h1357_9BDF;
        repeat (3) @(negedge clk);
        chk("pre_reset_mem_en", 32'(mem_en), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("midrst_mem_en", 32'(mem_en), 32'd0);
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_io_out", io_out, 32'd0);
        chk("midrst_err", 32'(err), 32'd0);
        chk("midrst_stall", 32'(stall), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        rst       = 1'b1;
        idle(3);
        chk("post_rst_mem_en", 32'(mem_en), 32'd0);

        // Misaligned, then back-to-back requests
        access(1'b0, 32'h0000_0006, 32'h0, -1, 32'h0, 32'h0, 1'b1, 1, 0, 10'd0);
        access(1'b0, 32'h0000_FF00, 32'h0, -1, 32'h0, 32'h0, 1'b1, 1, 0, 10'd0);
        access(1'b0, 32'h0000_0048, 32'h0, 0, 32'hABCD_0123, 32'hABCD_0123, 1'b1, 2, 1, 10'd18);
        access(1'b1, 32'h0000_0102, 32'h0000_FFFF, -1, 32'h0, 32'h0, 1'b1, 1, 0, 10'd0);
        idle(2);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
